// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit counter branch predictor (IF lookup) and branch/jump resolver with table training (ID)
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   if_valid, if_pc             fetch lookup -> pred_taken, pred_target
//   id_*                        ID-stage instruction, condition flags, target and carried prediction
//   hazard                      load-use stall: suppresses resolution and training
//   redirect, redirect_pc       corrected next PC on mispredict or jump
//   IF_Flush                    squash IF/ID
//   stat_branches, stat_mispredict  event counters, built only with BRANCH_PREDICT_STATS_EN
module branch_predict_unit #(
    parameter int         BHT_DEPTH = 64,
    parameter int         PC_W      = 32,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            id_valid,
    input  logic [PC_W-1:0] id_pc,
    input  logic [5:0]      id_opcode,
    input  logic            id_equal,
    input  logic            id_rs_zero,
    input  logic            id_rs_neg,
    input  logic            id_jump,
    input  logic [PC_W-1:0] id_target,
    input  logic            id_pred_taken,
    input  logic            hazard,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            IF_Flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredict
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]           ctr [BHT_DEPTH];
    logic [PC_W-1:0]      tgt [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] val;
    logic [IDX_W-1:0]     idx, uidx;
    logic                 is_cond, actual, active, mispred, upd;
    logic                 unused_pc;

    // Tag-less table: PC bits above the index and the byte offset are ignored.
    assign unused_pc = ^if_pc;

    assign idx         = if_pc[IDX_W+1:2];
    assign uidx        = id_pc[IDX_W+1:2];
    assign pred_taken  = if_valid & val[idx] & ctr[idx][1];
    assign pred_target = tgt[idx];

    // Opcodes 4..7 are beq/bne/blez/bgtz, selected by the low two bits.
    assign is_cond = id_opcode[5:2] == 4'b0001;
    assign actual  = id_opcode[1] ? (id_opcode[0] ? (!id_rs_neg & !id_rs_zero) : (id_rs_neg | id_rs_zero))
                                  : (id_opcode[0] ? !id_equal : id_equal);

    assign active      = !reset & !hazard & id_valid;
    assign upd         = active & !id_jump & is_cond;
    assign mispred     = upd & (actual != id_pred_taken);
    assign redirect    = (active & id_jump) | mispred;
    assign IF_Flush    = redirect;
    // A not-taken mispredict falls through; everything else (including idle) shows id_target.
    assign redirect_pc = (mispred & !actual) ? id_pc + PC_W'(4) : id_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr[i] <= CTR_INIT;
                tgt[i] <= '0;
            end
            val <= '0;
        end else if (upd) begin
            ctr[uidx] <= actual ? (ctr[uidx] == 2'd3 ? 2'd3 : ctr[uidx] + 2'd1)
                                : (ctr[uidx] == 2'd0 ? 2'd0 : ctr[uidx] - 2'd1);
            if (actual) begin
                tgt[uidx] <= id_target;
                val[uidx] <= 1'b1;
            end
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches   <= '0;
            stat_mispredict <= '0;
        end else if (upd) begin
            stat_branches   <= stat_branches + 32'd1;
            stat_mispredict <= stat_mispredict + {31'd0, mispred};
        end
    end
`else
    assign stat_branches   = '0;
    assign stat_mispredict = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vector table for branch_predict_unit
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        reset, if_valid, id_valid, id_equal, id_rs_zero, id_rs_neg, id_jump, id_pred_taken, hazard;
    logic [31:0] if_pc, id_pc, id_target;
    logic [5:0]  id_opcode;
    logic        pred_taken, redirect, IF_Flush;
    logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredict;

    int checks = 0;
    int fails  = 0;
    int exp_br = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_equal(id_equal),
        .id_rs_zero(id_rs_zero), .id_rs_neg(id_rs_neg), .id_jump(id_jump), .id_target(id_target),
        .id_pred_taken(id_pred_taken), .hazard(hazard),
        .redirect(redirect), .redirect_pc(redirect_pc), .IF_Flush(IF_Flush),
        .stat_branches(stat_branches), .stat_mispredict(stat_mispredict)
    );

    typedef struct {
        logic        rst;
        logic        ifv;
        logic [31:0] ifpc;
        logic        idv;
        logic [31:0] idpc;
        logic [5:0]  op;
        logic        eq, rz, rn, jmp;
        logic [31:0] tgt;
        logic        pt, hz;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_rd;
        logic [31:0] e_rpc;
        logic        e_fl;
    } vec_t;

    vec_t vt [28];

    task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, n, act, exp);
        end
    endtask

    initial begin
        //          rst ifv ifpc      idv idpc          op eq rz rn jmp tgt       pt hz  e_pt e_ptgt    e_rd e_rpc       e_fl
        vt[0]  = '{1'b1,1'b0,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h80, 1'b0};
        vt[1]  = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b0,32'h0,   1'b1,32'h80, 1'b1};
        vt[2]  = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b1,32'h80,  1'b1,32'h80, 1'b1};
        vt[3]  = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b1,1'b0, 1'b1,32'h80,  1'b0,32'h80, 1'b0};
        vt[4]  = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd5,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b1,1'b0, 1'b1,32'h80,  1'b1,32'h44, 1'b1};
        vt[5]  = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd5,1'b1,1'b0,1'b0,1'b0,32'h200,1'b1,1'b0, 1'b1,32'h80,  1'b0,32'h200,1'b0};
        vt[6]  = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd5,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b1,1'b0, 1'b1,32'h80,  1'b1,32'h44, 1'b1};
        vt[7]  = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b0,32'h80,  1'b0,32'h80, 1'b0};
        vt[8]  = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd7,1'b0,1'b0,1'b0,1'b0,32'h300,1'b0,1'b1, 1'b0,32'h80,  1'b0,32'h300,1'b0};
        vt[9]  = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h80,  1'b0,32'h0,  1'b0};
        vt[10] = '{1'b0,1'b1,32'h140,1'b1,32'h140,6'd2,1'b0,1'b0,1'b0,1'b1,32'h100,1'b0,1'b0, 1'b0,32'h80,  1'b1,32'h100,1'b1};
        vt[11] = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h80,  1'b0,32'h0,  1'b0};
        vt[12] = '{1'b0,1'b1,32'h40, 1'b1,32'h140,6'd6,1'b0,1'b1,1'b0,1'b0,32'h180,1'b0,1'b0, 1'b0,32'h80,  1'b1,32'h180,1'b1};
        vt[13] = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h180, 1'b0,32'h0,  1'b0};
        vt[14] = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd6,1'b0,1'b0,1'b0,1'b0,32'h999,1'b1,1'b0, 1'b1,32'h180, 1'b1,32'h44, 1'b1};
        vt[15] = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd7,1'b0,1'b0,1'b1,1'b0,32'h500,1'b0,1'b0, 1'b0,32'h180, 1'b0,32'h500,1'b0};
        vt[16] = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd7,1'b0,1'b0,1'b1,1'b0,32'h500,1'b0,1'b0, 1'b0,32'h180, 1'b0,32'h500,1'b0};
        vt[17] = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h180, 1'b0,32'h0,  1'b0};
        vt[18] = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b0,32'h180, 1'b1,32'h80, 1'b1};
        vt[19] = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h80,  1'b0,32'h0,  1'b0};
        vt[20] = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b0,32'h80,  1'b1,32'h80, 1'b1};
        vt[21] = '{1'b0,1'b0,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h80,  1'b0,32'h0,  1'b0};
        vt[22] = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b1,32'h80,  1'b0,32'h0,  1'b0};
        vt[23] = '{1'b0,1'b1,32'h40, 1'b1,32'hFFFFFFFC,6'd5,1'b1,1'b0,1'b0,1'b0,32'h80,1'b1,1'b0,1'b1,32'h80,1'b1,32'h0,  1'b1};
        vt[24] = '{1'b0,1'b1,32'h40, 1'b1,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h80, 1'b1,1'b0, 1'b1,32'h80,  1'b0,32'h80, 1'b0};
        vt[25] = '{1'b1,1'b0,32'h40, 1'b1,32'h40, 6'd4,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0, 1'b0,32'h80,  1'b0,32'h80, 1'b0};
        vt[26] = '{1'b0,1'b1,32'h40, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,  1'b0};
        vt[27] = '{1'b0,1'b1,32'hFC, 1'b0,32'h40, 6'd0,1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0, 1'b0,32'h0,   1'b0,32'h0,  1'b0};

        reset = 1'b1; if_valid = 1'b0; if_pc = '0; id_valid = 1'b0; id_pc = '0; id_opcode = '0;
        id_equal = 1'b0; id_rs_zero = 1'b0; id_rs_neg = 1'b0; id_jump = 1'b0; id_target = '0;
        id_pred_taken = 1'b0; hazard = 1'b0;
        repeat (2) @(posedge clk);

        for (int n = 0; n < 28; n++) begin
            #1;
            reset = vt[n].rst; if_valid = vt[n].ifv; if_pc = vt[n].ifpc; id_valid = vt[n].idv;
            id_pc = vt[n].idpc; id_opcode = vt[n].op; id_equal = vt[n].eq; id_rs_zero = vt[n].rz;
            id_rs_neg = vt[n].rn; id_jump = vt[n].jmp; id_target = vt[n].tgt;
            id_pred_taken = vt[n].pt; hazard = vt[n].hz;
            #4;
            check("pred_taken", n, {31'd0, pred_taken}, {31'd0, vt[n].e_pt});
            check("pred_target", n, pred_target, vt[n].e_ptgt);
            check("redirect", n, {31'd0, redirect}, {31'd0, vt[n].e_rd});
            check("redirect_pc", n, redirect_pc, vt[n].e_rpc);
            check("IF_Flush", n, {31'd0, IF_Flush}, {31'd0, vt[n].e_fl});
`ifdef BRANCH_PREDICT_STATS_EN
            check("stat_branches", n, stat_branches, exp_br);
            check("stat_mispredict", n, stat_mispredict, exp_mis);
`else
            check("stat_branches", n, stat_branches, 32'd0);
            check("stat_mispredict", n, stat_mispredict, 32'd0);
`endif
            if (vt[n].rst) begin
                exp_br = 0;
                exp_mis = 0;
            end else if (vt[n].idv && !vt[n].hz && !vt[n].jmp && vt[n].op >= 6'd4 && vt[n].op <= 6'd7) begin
                exp_br++;
                if (vt[n].e_rd) exp_mis++;
            end
            @(posedge clk);
        end

        // Reset held a second cycle with a taken branch presented: nothing may train.
        #1;
        reset = 1'b1; if_valid = 1'b1; if_pc = 32'h40; id_valid = 1'b1; id_pc = 32'h40;
        id_opcode = 6'd4; id_equal = 1'b1; id_pred_taken = 1'b0; id_target = 32'h80;
        #4;
        check("reset_redirect", 99, {31'd0, redirect}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0; id_valid = 1'b0;
        #4;
        check("post_reset_pred", 100, {31'd0, pred_taken}, 32'd0);
        check("post_reset_target", 100, pred_target, 32'd0);
        check("post_reset_stats", 100, stat_branches | stat_mispredict, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
